// File: rtl/spi_mem_rr_arbiter_if.sv
// Request/grant bundle between the SPI memory clients and the round-robin arbiter.
interface spi_mem_rr_arbiter_if #(parameter int N = 4);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]     req;
   logic [N-1:0]     en_mask;
   logic [N-1:0]     grant;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             preempt;

   modport master (output req, en_mask, input grant, grant_valid, grant_idx, preempt);
   modport slave  (input req, en_mask, output grant, grant_valid, grant_idx, preempt);
endinterface

// File: rtl/spi_mem_rr_arbiter.sv
// Round-robin owner selection for the shared SPI memory controller, with enable
// mask, hold-time preemption and an optional idle gap so CS can deassert.
module spi_mem_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int GAP      = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_mem_rr_arbiter_if.slave  bus
);
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [N-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic               gvld_q, gvld_d;
   logic               pre_q, pre_d;

   logic [N-1:0]       ereq, others;
   logic               expire, drop, take;
   logic [IDX_W:0]     pick;
   logic [IDX_W-1:0]   new_idx;

   // {found, idx}: first set bit of r searching cyclically from 'from'+1,
   // so 'from' itself is the last candidate considered.
   function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r,
                                              input logic [IDX_W-1:0] from);
      logic [2*N-1:0]   dbl;
      logic [N-1:0]     rot;
      logic             found;
      logic [IDX_W-1:0] idx;
      dbl   = {r, r} >> (int'(from) + 1);
      rot   = dbl[N-1:0];
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = IDX_W'((int'(from) + 1 + k) % N);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      gvld_d  = gvld_q;
      pre_d   = 1'b0;
      ereq    = bus.req & bus.en_mask;
      others  = ereq & ~(N'(1) << last_q);
      expire  = 1'b0;
      drop    = 1'b0;
      take    = 1'b0;
      pick    = '0;
      case (state_q)
         S_IDLE: begin
            pick = rr_pick(ereq, last_q);
            take = pick[IDX_W];
         end
         S_GRANT: begin
            expire = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD)) && (others != '0);
            if (ereq[last_q] && !expire) begin
               if (MAX_HOLD != 0 && hold_q != HOLD_W'(MAX_HOLD)) hold_d = hold_q + 1'b1;
            end else begin
               // A holder that dropped its request on the expiry cycle is a plain release.
               pre_d = ereq[last_q];
               drop  = 1'b1;
               if (GAP == 0) begin
                  pick = rr_pick(others, last_q);
                  take = pick[IDX_W];
                  if (!take) state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAP_W'(GAP);
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_W'(1)) begin
               pick = rr_pick(ereq, last_q);
               take = pick[IDX_W];
               if (!take) state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      new_idx = pick[IDX_W-1:0];
      if (drop) begin
         grant_d = '0;
         gidx_d  = '0;
         gvld_d  = 1'b0;
      end
      if (take) begin
         state_d = S_GRANT;
         last_d  = new_idx;
         hold_d  = HOLD_W'(1);
         grant_d = N'(1) << new_idx;
         gidx_d  = new_idx;
         gvld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(N - 1);
         hold_q  <= '0;
         gap_q   <= '0;
         grant_q <= '0;
         gidx_q  <= '0;
         gvld_q  <= 1'b0;
         pre_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         gvld_q  <= gvld_d;
         pre_q   <= pre_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = gidx_q;
   assign bus.grant_valid = gvld_q;
   assign bus.preempt     = pre_q;
endmodule

// File: tb/tb_spi_mem_rr_arbiter.sv
// Four arbiter configurations driven with shared stimulus and checked against
// an ownership-level model plus directed expectations.
module tb_spi_mem_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, en;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   spi_mem_rr_arbiter_if #(.N(4)) if0 ();
   spi_mem_rr_arbiter_if #(.N(4)) if1 ();
   spi_mem_rr_arbiter_if #(.N(4)) if2 ();
   spi_mem_rr_arbiter_if #(.N(4)) if3 ();

   assign if0.req = req;  assign if0.en_mask = en;
   assign if1.req = req;  assign if1.en_mask = en;
   assign if2.req = req;  assign if2.en_mask = en;
   assign if3.req = req;  assign if3.en_mask = en;

   spi_mem_rr_arbiter #(.N(4), .MAX_HOLD(0), .GAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   spi_mem_rr_arbiter #(.N(4), .MAX_HOLD(4), .GAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   spi_mem_rr_arbiter #(.N(4), .MAX_HOLD(0), .GAP(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   spi_mem_rr_arbiter #(.N(4), .MAX_HOLD(3), .GAP(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   logic [3:0] g  [4];
   logic [1:0] gi [4];
   logic       gv [4];
   logic       pr [4];
   assign g[0] = if0.grant; assign gi[0] = if0.grant_idx; assign gv[0] = if0.grant_valid; assign pr[0] = if0.preempt;
   assign g[1] = if1.grant; assign gi[1] = if1.grant_idx; assign gv[1] = if1.grant_valid; assign pr[1] = if1.preempt;
   assign g[2] = if2.grant; assign gi[2] = if2.grant_idx; assign gv[2] = if2.grant_valid; assign pr[2] = if2.preempt;
   assign g[3] = if3.grant; assign gi[3] = if3.grant_idx; assign gv[3] = if3.grant_valid; assign pr[3] = if3.preempt;

   // Reference model: who owns the bus, for how long, idle cycles still owed.
   int MHc  [4] = '{0, 4, 0, 3};
   int GAPc [4] = '{0, 0, 2, 1};
   int owner[4], held[4], gapl[4], lastp[4];
   bit pre  [4];

   function automatic int pick_from(input int r, input int from);
      for (int k = 1; k <= 4; k++) begin
         int p;
         p = (from + k) % 4;
         if (r[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_g(input int k);
      return (owner[k] >= 0) ? 4'(1 << owner[k]) : 4'b0000;
   endfunction

   function automatic logic [1:0] exp_i(input int k);
      return (owner[k] >= 0) ? 2'(owner[k]) : 2'd0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         owner[k] = -1; held[k] = 0; gapl[k] = 0; lastp[k] = 3; pre[k] = 0;
      end
   endtask

   task automatic model_step();
      int er, h, w;
      bit keeps, others_wait;
      er = int'(req & en);
      for (int k = 0; k < 4; k++) begin
         pre[k] = 0;
         w = -1;
         if (owner[k] >= 0) begin
            h = owner[k];
            others_wait = (er & ~(1 << h)) != 0;
            keeps = er[h] && !(MHc[k] != 0 && held[k] >= MHc[k] && others_wait);
            if (keeps) begin
               if (MHc[k] == 0 || held[k] < MHc[k]) held[k]++;
            end else begin
               pre[k]   = er[h];
               owner[k] = -1;
               if (GAPc[k] == 0) w = pick_from(er & ~(1 << h), h);
               else gapl[k] = GAPc[k];
            end
         end else if (gapl[k] > 1) begin
            gapl[k]--;
         end else begin
            gapl[k] = 0;
            w = pick_from(er, lastp[k]);
         end
         if (w >= 0) begin
            owner[k] = w; held[k] = 1; lastp[k] = w;
         end
      end
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic tick();
      if (rst_n) model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      req = 4'b0000;
      en  = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req = 4'b0000; en = 4'b1111; rst_n = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({g[k], gi[k], gv[k], pr[k]} !== 8'h00) begin
            errors++;
            $display("FAIL reset dut%0d: grant=%b idx=%0d vld=%b pre=%b, expected all zero", k, g[k], gi[k], gv[k], pr[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      req = 4'b0001; tick();
      checks++;
      if (g[0] !== 4'b0001 || gi[0] !== 2'd0 || gv[0] !== 1'b1) begin
         errors++; $display("FAIL basic_first: grant=%b idx=%0d vld=%b, expected 0001 0 1", g[0], gi[0], gv[0]);
      end
      req = 4'b0111; tick();
      checks++;
      if (g[0] !== 4'b0001) begin
         errors++; $display("FAIL basic_sticky: grant=%b, expected 0001", g[0]);
      end
      req = 4'b0110; tick();
      checks++;
      if (g[0] !== 4'b0010 || gi[0] !== 2'd1) begin
         errors++; $display("FAIL basic_handover: grant=%b idx=%0d, expected 0010 1", g[0], gi[0]);
      end
      req = 4'b0000; tick();
      checks++;
      if (g[0] !== 4'b0000 || gv[0] !== 1'b0) begin
         errors++; $display("FAIL basic_idle: grant=%b vld=%b, expected 0000 0", g[0], gv[0]);
      end
   endtask

   task automatic test_round_robin();
      int seq[$], runs[$];
      int prev, cur;
      string s;
      do_reset();
      prev = -2;
      req  = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         tick();
         cur = (g[0] == 4'b0000) ? -1 : int'(gi[0]);
         if (cur != prev) begin seq.push_back(cur); runs.push_back(1); end
         else runs[runs.size()-1]++;
         prev = cur;
         req = (runs[runs.size()-1] == 3) ? (4'b1111 & ~g[0]) : 4'b1111;
      end
      s = "";
      foreach (seq[i]) s = {s, $sformatf("%0d(%0d) ", seq[i], runs[i])};
      checks++;
      if (seq.size() < 5 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 0) begin
         errors++; $display("FAIL rr_order: got %s, expected 0 1 2 3 0", s);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (runs.size() <= i || runs[i] != 3) begin
            errors++; $display("FAIL rr_hold%0d: got %s, expected each grant 3 cycles", i, s);
         end
      end
   endtask

   task automatic test_preempt();
      int cnt;
      do_reset();
      cnt = 0;
      req = 4'b0001;
      tick(); if (g[1] === 4'b0001) cnt++;
      tick(); if (g[1] === 4'b0001) cnt++;
      req = 4'b0101;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (g[1] === 4'b0001) cnt++;
         else break;
      end
      checks++;
      if (cnt != 4) begin errors++; $display("FAIL preempt_len: held %0d cycles, expected 4", cnt); end
      checks++;
      if (g[1] !== 4'b0100 || pr[1] !== 1'b1) begin
         errors++; $display("FAIL preempt_switch: grant=%b pre=%b, expected 0100 1", g[1], pr[1]);
      end
      tick();
      checks++;
      if (g[1] !== 4'b0100 || pr[1] !== 1'b0) begin
         errors++; $display("FAIL preempt_pulse: grant=%b pre=%b, expected 0100 0", g[1], pr[1]);
      end
      req = 4'b0001; tick();
      checks++;
      if (g[1] !== 4'b0001) begin errors++; $display("FAIL preempt_return: grant=%b, expected 0001", g[1]); end
   endtask

   task automatic test_hold_single();
      int bad;
      do_reset();
      bad = 0;
      req = 4'b0010;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (g[1] !== 4'b0010 || pr[1] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_single: %0d bad cycles, expected 0", bad); end
   endtask

   task automatic test_gap();
      logic [3:0] want [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
      do_reset();
      req = 4'b0011; tick(); tick();
      for (int c = 0; c < 4; c++) begin
         if (c == 1) req = 4'b0010;
         if (c > 0) tick();
         checks++;
         if (g[2] !== want[c]) begin
            errors++; $display("FAIL gap_step%0d: grant=%b, expected %b", c, g[2], want[c]);
         end
      end
   endtask

   task automatic test_mask();
      int bad;
      do_reset();
      en = 4'b1110; req = 4'b0001; bad = 0;
      for (int c = 0; c < 3; c++) begin tick(); if (g[0] !== 4'b0000) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mask_block: %0d cycles granted, expected none", bad); end
      req = 4'b0011; tick();
      checks++;
      if (g[0] !== 4'b0010) begin errors++; $display("FAIL mask_grant1: grant=%b, expected 0010", g[0]); end
      en = 4'b1100; tick();
      checks++;
      if (g[0] !== 4'b0000) begin errors++; $display("FAIL mask_drop: grant=%b, expected 0000", g[0]); end
      en = 4'b1111; tick();
      checks++;
      if (g[0] !== 4'b0001) begin errors++; $display("FAIL mask_reenable: grant=%b, expected 0001", g[0]); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({g[k], gi[k], gv[k], pr[k]} !== 8'h00) begin
            errors++; $display("FAIL midreset dut%0d: grant=%b idx=%0d vld=%b, expected zero", k, g[k], gi[k], gv[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b0111; en = 4'b1110; tick();
      checks++;
      if (g[0] !== 4'b0010 || gi[0] !== 2'd1) begin
         errors++; $display("FAIL postreset_first: grant=%b idx=%0d, expected 0010 1", g[0], gi[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         req = req ^ 4'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 9) == 0) en = 4'($urandom);
         else if ($urandom_range(0, 5) == 0) en = 4'b1111;
         if ($urandom_range(0, 249) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick();
         for (int k = 0; k < 4; k++) begin
            checks++;
            if ({g[k], gi[k], gv[k], pr[k]} !== {exp_g(k), exp_i(k), owner[k] >= 0, pre[k]}) begin
               errors++;
               $display("FAIL rand dut%0d cyc%0d: grant=%b idx=%0d vld=%b pre=%b, expected grant=%b idx=%0d vld=%b pre=%b",
                        k, c, g[k], gi[k], gv[k], pr[k], exp_g(k), exp_i(k), owner[k] >= 0, pre[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_preempt();
      test_hold_single();
      test_gap();
      test_mask();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
